// File: rtl/counter_pkg.sv
// Shared types and constants for the run/stop/clear counter.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int CNT_W = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = 14'd9999;

    // One count step in the 0..CNT_MAX ring, wrapping at both ends.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] val,
                                                  input logic             down);
        logic [CNT_W-1:0] res;
        if (down) begin
            res = (val == '0) ? CNT_MAX : val - 14'd1;
        end else begin
            res = (val >= CNT_MAX) ? '0 : val + 14'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronise, debounce and edge-detect one raw push-button into a press pulse.
// Latency: 2 sync cycles + DEB_LEN strobes + 1 cycle from a clean edge to press_o.
// Backpressure: none; press_o is a 1-cycle pulse, release produces nothing.
module btn_debounce #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic smp_stb_i,
    output logic press_o
);

    logic               sync1_q;
    logic               sync2_q;
    logic [DEB_LEN-1:0] sh_q;
    logic               lvl_q;
    logic               press_q;
    logic               all_one;
    logic               all_zero;

    assign all_one  = &sh_q;
    assign all_zero = ~|sh_q;

    // Sync the raw input, shift samples on the shared strobe, hold the level
    // until the window is unanimous, and pulse once on the level's rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sh_q    <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (smp_stb_i) begin
                sh_q <= {sh_q[DEB_LEN-2:0], sync2_q};
            end
            if (all_one) begin
                lvl_q <= 1'b1;
            end else if (all_zero) begin
                lvl_q <= 1'b0;
            end
            press_q <= all_one & ~lvl_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/stop/clear controller driving a 0..9999 up/down counter from three buttons.
// Latency: outputs change 1 cycle after a press pulse; cnt_val 1 cycle after a step strobe.
// Backpressure: none; every accepted press and every tick is acted on immediately.
module counter_run_ctrl
    import counter_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int DEB_DIV  = 100_000,
    parameter int DEB_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_run,
    input  logic             btn_clear,
    input  logic             btn_mode,
    output logic [CNT_W-1:0] cnt_val,
    output logic             running,
    output logic             dir_down
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SMP_W  = $clog2(DEB_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(DEB_DIV - 1);

    logic [SMP_W-1:0]  smp_q;
    logic              smp_stb;
    logic              p_run;
    logic              p_clr;
    logic              p_mode;
    state_t            state_q;
    logic [TICK_W-1:0] tick_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              run_q;
    logic              dir_q;
    logic              step;

    assign smp_stb = (smp_q == SMP_LAST);

    // Free-running sample divider; one strobe shared by all three buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q <= '0;
        end else if (smp_stb) begin
            smp_q <= '0;
        end else begin
            smp_q <= smp_q + SMP_W'(1);
        end
    end

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_run (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_run),
        .smp_stb_i (smp_stb),
        .press_o   (p_run)
    );

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_clr (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_clear),
        .smp_stb_i (smp_stb),
        .press_o   (p_clr)
    );

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_mode (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_mode),
        .smp_stb_i (smp_stb),
        .press_o   (p_mode)
    );

    // The step is computed from the current direction, so a mode press landing
    // on the same cycle only affects later steps.
    assign step  = (state_q == ST_RUN) && (tick_q == TICK_LAST);
    assign cnt_d = cnt_step(cnt_q, dir_q);

    // Run/stop/clear sequencing with the tick divider and counter; clear wins
    // over run, and a stop press still lets a coincident step land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            tick_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            if (p_mode) begin
                dir_q <= ~dir_q;
            end
            case (state_q)
                ST_STOP: begin
                    tick_q <= '0;
                    if (p_clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        run_q   <= 1'b0;
                    end else if (p_run) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (p_clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        run_q   <= 1'b0;
                        tick_q  <= '0;
                    end else begin
                        if (step) begin
                            cnt_q <= cnt_d;
                        end
                        if (p_run) begin
                            state_q <= ST_STOP;
                            run_q   <= 1'b0;
                            tick_q  <= '0;
                        end else if (step) begin
                            tick_q <= '0;
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_STOP;
                    cnt_q   <= '0;
                    run_q   <= 1'b0;
                    tick_q  <= '0;
                end
                default: begin
                    state_q <= ST_STOP;
                    run_q   <= 1'b0;
                    tick_q  <= '0;
                end
            endcase
        end
    end

    assign cnt_val  = cnt_q;
    assign running  = run_q;
    assign dir_down = dir_q;

endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Run/stop/clear controller for the 4-digit 0–9999 counter display. It debounces three push-buttons, sequences a STOP/RUN/CLEAR state machine, and advances a BCD-range up/down counter on an internal tick. Its 14-bit output feeds the display controller's `in_val` directly.

## Interface

Parameters:
- `TICK_DIV`, default 10_000_000 — clk cycles per count step (10 Hz at 100 MHz); must be ≥ 2.
- `DEB_DIV`, default 100_000 — clk cycles between debounce samples (1 ms at 100 MHz); must be ≥ 2.
- `DEB_LEN`, default 4 — consecutive equal samples required to accept a level; must be ≥ 2.

Ports:
- `clk`  in  1 — system clock; the only clock.
- `rst`  in  1 — reset, asynchronous, active-high.
- `btn_run`  in  1 — raw button, asynchronous to `clk`; each accepted press toggles run/stop.
- `btn_clear`  in  1 — raw button; each accepted press zeroes the count and stops.
- `btn_mode`  in  1 — raw button; each accepted press toggles count direction.
- `cnt_val`  out  14 — current count, 0..9999.
- `running`  out  1 — 1 while in RUN.
- `dir_down`  out  1 — 0 = count up, 1 = count down.

## Operation

- **Button path, per button:**
  - 2-flop synchronizer.
  - A sample strobe fires every `DEB_DIV` cycles; one strobe is shared by all three buttons.
  - A `DEB_LEN`-bit shift register is loaded on each strobe.
  - The debounced level goes 1 when all bits are 1 and 0 when all bits are 0; otherwise it holds.
  - A rising edge of the debounced level gives a 1-cycle press pulse (`p_run`, `p_clr`, `p_mode`). Release produces no pulse.
- **FSM states:** STOP, RUN, CLEAR.
  - STOP: `p_clr` → CLEAR; else `p_run` → RUN.
  - RUN: `p_clr` → CLEAR; else `p_run` → STOP.
  - CLEAR: for exactly one cycle, `cnt_val` is loaded with 0; unconditionally → STOP. Pulses arriving in this cycle are ignored, except `p_mode`.
  - `p_clr` has priority over a simultaneous `p_run`.
- **Direction:** `p_mode` toggles `dir_down` in any state, including CLEAR. The count value is unaffected.
- **Tick divider:**
  - Counts 0..`TICK_DIV`-1 only while in RUN and wraps to 0.
  - Forced to 0 in STOP and CLEAR.
  - Step strobe = divider at `TICK_DIV`-1 while in RUN.
- **Count arithmetic** (14-bit unsigned; values above 9999 are never produced):
  - Up: 9999 → 0; otherwise +1.
  - Down: 0 → 9999; otherwise −1.
  - A step and a `p_mode` in the same cycle: the step uses the old direction.
  - A step and a `p_run` (→STOP) in the same cycle: the step is still applied.
  - A step and a `p_clr` in the same cycle: the clear wins, and `cnt_val` becomes 0 on entering CLEAR.

## Timing

- **Reset values:**
  - `cnt_val` = 0, `running` = 0, `dir_down` = 0.
  - State = STOP; divider, sample counter, shift registers and debounced levels all = 0.
- **Reset mid-operation:** reset is honored immediately, without waiting for `clk`. Any count, direction or partial debounce is discarded.
- **Button latency:** from a clean input edge to the press pulse is 2 sync cycles plus between (`DEB_LEN`-1)·`DEB_DIV` and `DEB_LEN`·`DEB_DIV` cycles, plus 1.
- **Transitions:**
  - The FSM transition is registered: `running` changes 1 cycle after the pulse.
  - The first step after entering RUN occurs `TICK_DIV` cycles after `running` rises.
  - Thereafter, one step every `TICK_DIV` cycles.
  - `cnt_val` updates 1 cycle after the step strobe.
- **Registering:** all outputs come straight from registers, with no combinational path from the buttons.

## Structure

- **Shared package** `counter_pkg`:
  - State encoding (STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2).
  - `CNT_MAX` = 9999.
  - `CNT_W` = 14.
- **Sub-module** `btn_debounce`:
  - Contains the synchronizer, shift register, level logic and edge pulse.
  - Input: the sample strobe from the parent.
  - Instantiated 3×.
- **Parent** holds the sample-strobe divider, the FSM, the tick divider and the counter.

## Test plan

Benches use `TICK_DIV`=10, `DEB_DIV`=4, `DEB_LEN`=4.

- **Reset and first run:** after reset, check `cnt_val`=0, `running`=0, `dir_down`=0. Press `btn_run` cleanly for 40 cycles → `running`=1. Then 10 cycles later `cnt_val`=1, and after 50 more cycles `cnt_val`=6.
- **Bounce rejection:** toggle `btn_run` every 3 cycles for 30 cycles, then hold it low → no press pulse and `running` stays 0. Hold it high for 20 cycles → exactly one pulse.
- **Wrap, both directions:**
  - Force-load 9998 via run-up, then run 2 steps → 9999, then 0.
  - With `dir_down`=1 starting from 0, one step → 9999.
- **Clear priority:** in RUN with `cnt_val`=37, make `btn_run` and `btn_clear` accepted in the same cycle → CLEAR for 1 cycle, then STOP with `cnt_val`=0 and `running`=0.
- **Mode during run:** in RUN, pressing `btn_mode` coincident with a step strobe → that step goes in the old direction and the next step goes in the new one. `cnt_val` is not otherwise disturbed.
- **Async reset mid-count:** assert `rst` for 3 ns between clock edges with `cnt_val`=123 and `dir_down`=1 → all outputs are 0 before the next edge and stay at reset values until a new press.
